elastic_context_pe: RTL

ELASTIC_CONTEXT_PE -- requirements
Module: elastic_context_pe

---
 rtl/elastic_context_pe_pkg.sv | 45 ++++
 rtl/elastic_context_pe_fork_fifo.sv | 89 ++++++++
 rtl/elastic_context_pe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/elastic_context_pe_pkg.sv
// Shared definitions for the elastic context PE: ALU op codes, the control
// FSM state encoding and the width-independent part of a configuration entry.
package elastic_context_pe_pkg;

  localparam int unsigned REPEAT_W = 8;
  localparam int unsigned ITER_W   = 16;

  typedef enum logic [3:0] {
    OP_PASS_A    = 4'd0,
    OP_ADD       = 4'd1,
    OP_SUB       = 4'd2,
    OP_MUL       = 4'd3,
    OP_AND       = 4'd4,
    OP_OR        = 4'd5,
    OP_XOR       = 4'd6,
    OP_CONST     = 4'd7,
    OP_ADD_CONST = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Operand selects, output mask and constant depend on module parameters,
  // so they live in parallel arrays beside this struct in the top level.
  typedef struct packed {
    op_e                 op;
    logic [REPEAT_W-1:0] repeat_max;
  } cfg_ctrl_t;

  // Every op reads A except CONST (undefined codes act as PASS_A).
  function automatic logic op_needs_a(input op_e op);
    return op != OP_CONST;
  endfunction

  function automatic logic op_needs_b(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/elastic_context_pe_fork_fifo.sv
// elastic_fork_fifo: result FIFO whose head entry is forked to every output
// channel selected by that entry's mask. Each channel hands its copy over
// independently; the head pops once all masked channels have taken it.
//   push_valid/push_data/push_mask : enqueue request (taken when push_ready)
//   push_ready                     : count below DEPTH
//   empty                          : no entries held
//   out_data/out_valid/out_stop    : per-channel output handshake
module elastic_fork_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NEIGHBOR_NUM = 4,
  parameter int unsigned DEPTH        = 2
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     push_valid,
  input  logic [DATA_WIDTH-1:0]                    push_data,
  input  logic [NEIGHBOR_NUM-1:0]                  push_mask,
  output logic                                     push_ready,
  output logic                                     empty,
  output logic [NEIGHBOR_NUM-1:0][DATA_WIDTH-1:0]  out_data,
  output logic [NEIGHBOR_NUM-1:0]                  out_valid,
  input  logic [NEIGHBOR_NUM-1:0]                  out_stop
);

  localparam int unsigned     PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [NEIGHBOR_NUM-1:0] mask_q [DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [NEIGHBOR_NUM-1:0] sent_q, sent_d;
  logic [NEIGHBOR_NUM-1:0] head_mask, accept;
  logic                    push, pop;

  always_comb begin
    empty      = (count_q == '0);
    push_ready = (count_q < FULL_CNT);
    push       = push_valid && push_ready;
    head_mask  = mask_q[rd_ptr_q];
    out_valid  = empty ? '0 : (head_mask & ~sent_q);
    accept     = out_valid & ~out_stop;
    // Pop when no masked channel is left outstanding after this cycle;
    // an all-zero mask therefore pops on its first cycle at the head.
    pop        = !empty && ((head_mask & ~(sent_q | accept)) == '0);
    sent_d     = pop ? '0 : (sent_q | accept);

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    for (int unsigned k = 0; k < NEIGHBOR_NUM; k++) begin
      out_data[k] = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      if (push) begin
        data_q[wr_ptr_q] <= push_data;
        mask_q[wr_ptr_q] <= push_mask;
      end
    end
  end

endmodule

// File: rtl/elastic_context_pe.sv
// elastic_context_pe: context-sequenced processing element with elastic
// (valid/stop) neighbour channels. Each context selects two input channels,
// an ALU op, a constant, an output fork mask and a repeat count.
//   cfg_*                       : configuration memory write port
//   start_exec/stop_exec        : execution control, context_max_id wraps
//   in_data/in_valid/in_stop    : input channels
//   out_data/out_valid/out_stop : output channels (via elastic_fork_fifo)
//   busy/context_id/iteration_count : status
module elastic_context_pe
  import elastic_context_pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned NEIGHBOR_NUM  = 4,
  parameter int unsigned CONTEXT_DEPTH = 16,
  parameter int unsigned BUFFER_DEPTH  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    cfg_write,
  input  logic [$clog2(CONTEXT_DEPTH)-1:0]        cfg_index,
  input  logic [$clog2(NEIGHBOR_NUM)-1:0]         cfg_src_a,
  input  logic [$clog2(NEIGHBOR_NUM)-1:0]         cfg_src_b,
  input  logic [NEIGHBOR_NUM-1:0]                 cfg_out_mask,
  input  logic [3:0]                              cfg_op,
  input  logic [DATA_WIDTH-1:0]                   cfg_const,
  input  logic [7:0]                              cfg_repeat,
  input  logic                                    start_exec,
  input  logic                                    stop_exec,
  input  logic [$clog2(CONTEXT_DEPTH)-1:0]        context_max_id,
  input  logic [NEIGHBOR_NUM-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NEIGHBOR_NUM-1:0]                 in_valid,
  output logic [NEIGHBOR_NUM-1:0]                 in_stop,
  output logic [NEIGHBOR_NUM-1:0][DATA_WIDTH-1:0] out_data,
  output logic [NEIGHBOR_NUM-1:0]                 out_valid,
  input  logic [NEIGHBOR_NUM-1:0]                 out_stop,
  output logic                                    busy,
  output logic [$clog2(CONTEXT_DEPTH)-1:0]        context_id,
  output logic [15:0]                             iteration_count
);

  localparam int unsigned CTX_W = $clog2(CONTEXT_DEPTH);
  localparam int unsigned NB_W  = $clog2(NEIGHBOR_NUM);

  state_e              state_q, state_d;
  logic [CTX_W-1:0]    ctx_q, ctx_d;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic [ITER_W-1:0]   iter_q, iter_d;

  cfg_ctrl_t               ctrl_q  [CONTEXT_DEPTH];
  logic [NB_W-1:0]         src_a_q [CONTEXT_DEPTH];
  logic [NB_W-1:0]         src_b_q [CONTEXT_DEPTH];
  logic [NEIGHBOR_NUM-1:0] mask_q  [CONTEXT_DEPTH];
  logic [DATA_WIDTH-1:0]   const_q [CONTEXT_DEPTH];

  cfg_ctrl_t               cur_ctrl;
  logic [NB_W-1:0]         cur_src_a, cur_src_b;
  logic [NEIGHBOR_NUM-1:0] cur_mask;
  logic [DATA_WIDTH-1:0]   cur_const;
  logic [DATA_WIDTH-1:0]   op_a, op_b, alu_result;
  logic                    need_a, need_b, operands_ok, fire;
  logic                    fifo_ready, fifo_empty;

  // Datapath: operand selection, firing rule, input handshake, ALU.
  always_comb begin
    cur_ctrl  = ctrl_q[ctx_q];
    cur_src_a = src_a_q[ctx_q];
    cur_src_b = src_b_q[ctx_q];
    cur_mask  = mask_q[ctx_q];
    cur_const = const_q[ctx_q];
    op_a      = in_data[cur_src_a];
    op_b      = in_data[cur_src_b];
    need_a    = op_needs_a(cur_ctrl.op);
    need_b    = op_needs_b(cur_ctrl.op);
    operands_ok = (!need_a || in_valid[cur_src_a]) &&
                  (!need_b || in_valid[cur_src_b]);
    fire = (state_q == ST_RUN) && !start_exec && !stop_exec &&
           operands_ok && fifo_ready;

    // src_a == src_b releases one channel only, so one token feeds both.
    in_stop = '1;
    if (fire) begin
      if (need_a) in_stop[cur_src_a] = 1'b0;
      if (need_b) in_stop[cur_src_b] = 1'b0;
    end

    case (cur_ctrl.op)
      OP_ADD:       alu_result = op_a + op_b;
      OP_SUB:       alu_result = op_a - op_b;
      OP_MUL:       alu_result = op_a * op_b;
      OP_AND:       alu_result = op_a & op_b;
      OP_OR:        alu_result = op_a | op_b;
      OP_XOR:       alu_result = op_a ^ op_b;
      OP_CONST:     alu_result = cur_const;
      OP_ADD_CONST: alu_result = op_a + cur_const;
      default:      alu_result = op_a;
    endcase
  end

  // Control FSM and context sequencing.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    rep_d   = rep_q;
    iter_d  = iter_q;

    case (state_q)
      ST_IDLE:  if (start_exec) state_d = ST_RUN;
      ST_RUN:   if (stop_exec)  state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (start_exec) begin
      state_d = ST_RUN;
      ctx_d   = '0;
      rep_d   = '0;
      iter_d  = '0;
    end else if (fire) begin
      if (rep_q == cur_ctrl.repeat_max) begin
        rep_d = '0;
        if (ctx_q == context_max_id) begin
          ctx_d  = '0;
          iter_d = iter_q + 1'b1;
        end else begin
          ctx_d = ctx_q + 1'b1;
        end
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      rep_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      rep_q   <= rep_d;
      iter_q  <= iter_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < CONTEXT_DEPTH; i++) begin
        ctrl_q[i]  <= '0;
        src_a_q[i] <= '0;
        src_b_q[i] <= '0;
        mask_q[i]  <= '0;
        const_q[i] <= '0;
      end
    end else if (cfg_write) begin
      ctrl_q[cfg_index]  <= '{op: op_e'(cfg_op), repeat_max: cfg_repeat};
      src_a_q[cfg_index] <= cfg_src_a;
      src_b_q[cfg_index] <= cfg_src_b;
      mask_q[cfg_index]  <= cfg_out_mask;
      const_q[cfg_index] <= cfg_const;
    end
  end

  elastic_fork_fifo #(
    .DATA_WIDTH   (DATA_WIDTH),
    .NEIGHBOR_NUM (NEIGHBOR_NUM),
    .DEPTH        (BUFFER_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (fire),
    .push_data  (alu_result),
    .push_mask  (cur_mask),
    .push_ready (fifo_ready),
    .empty      (fifo_empty),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_stop   (out_stop)
  );

  assign busy            = (state_q != ST_IDLE);
  assign context_id      = ctx_q;
  assign iteration_count = iter_q;

endmodule
